uart_cmd_parser: RTL

Byte-level command decoder that sits directly downstream of the UART receiver. It consumes each received byte, assembles fixed 5-byte command frames, and executes them against a single-port synchronous RAM. It answers every accepted frame with one response byte to the UART transmitter: ACK for a write, the read data for a read, or NAK on error.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_byte_strobe.sv | 45 ++++
 rtl/uart_cmd_parser.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART command parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam logic [7:0] HDR   = 8'hA5;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC_W,
        EXEC_R,
        RD_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/uart_byte_strobe.sv
// Byte strobe from the falling edge of rx_int plus inter-byte timeout counter.
// Latency: stb is combinational on the falling edge (one register on rx_int).
// Backpressure: none; the counter only runs while run is high.
module uart_byte_strobe #(
    parameter int TIMEOUT = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_int,
    input  logic run,
    output logic stb,
    output logic tmo
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic          rx_int_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign stb = rx_int_q & ~rx_int;
    // A byte arriving in the same cycle as expiry wins over the timeout.
    assign tmo = run & ~stb & (cnt_q == CNT_MAX);

    // Counter is held at zero outside a frame, cleared on every byte and on expiry.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run || stb || tmo) begin
            cnt_d = '0;
        end
    end

    // Edge-detect register and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_int_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rx_int_q <= rx_int;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte A5/CMD/ADDR/DATA/CHK frames and runs them against a sync RAM.
// Latency: write tx_en >= 2 cycles after CHK strobe, read tx_en >= 3 cycles.
// Backpressure: holds in RESP while tx_busy is high; bytes arriving meanwhile are dropped.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_int,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              frame_err,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              frame_err_q, frame_err_d;
    logic              stb, tmo, run;

    assign run = (state_q == GET_CMD) || (state_q == GET_ADDR) ||
                 (state_q == GET_DATA) || (state_q == GET_CHK);

    uart_byte_strobe #(
        .TIMEOUT (TIMEOUT)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_int (rx_int),
        .run    (run),
        .stb    (stb),
        .tmo    (tmo)
    );

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign tx_data   = tx_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

    // Next-state, datapath loads and the single-cycle strobes ram_we / tx_en.
    // The RAM address is loaded on the checksum byte so it is valid in the
    // first execute cycle for both reads and writes.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tx_data_d   = tx_data_q;
        frame_err_d = 1'b0;
        ram_we      = 1'b0;
        tx_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (stb && rx_data == HDR) state_d = GET_CMD;
            end
            GET_CMD, GET_ADDR, GET_DATA: begin
                if (tmo) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (stb) begin
                    if (state_q == GET_CMD) begin
                        cmd_d   = rx_data;
                        state_d = GET_ADDR;
                    end else if (state_q == GET_ADDR) begin
                        addr_d  = rx_data;
                        state_d = GET_DATA;
                    end else begin
                        data_d  = rx_data;
                        state_d = GET_CHK;
                    end
                end
            end
            GET_CHK: begin
                if (tmo) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (stb) begin
                    if (rx_data == (cmd_q ^ addr_q ^ data_q) && cmd_q == CMD_W) begin
                        ram_addr_d  = ADDR_W'(addr_q);
                        ram_wdata_d = data_q;
                        state_d     = EXEC_W;
                    end else if (rx_data == (cmd_q ^ addr_q ^ data_q) && cmd_q == CMD_R) begin
                        ram_addr_d = ADDR_W'(addr_q);
                        state_d    = EXEC_R;
                    end else begin
                        tx_data_d   = NAK;
                        frame_err_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            EXEC_W: begin
                ram_we    = 1'b1;
                tx_data_d = ACK;
                state_d   = RESP;
            end
            EXEC_R: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                tx_data_d = ram_rdata;
                state_d   = RESP;
            end
            RESP: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tx_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tx_data_q   <= tx_data_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
